// File: rtl/pat_run_ctrl_if.sv
// Program-load port of the pat run controller: the host streams instruction words,
// the controller accepts them while it is idle and has room.
interface pat_run_ctrl_if #(
  parameter int i_width = 15
) ();
  // A word transfers on the rising clk edge where load_valid && load_ready are both 1;
  // load_data is held stable while load_valid is high, and load_valid never waits on load_ready.
  logic               load_valid;
  logic               load_ready;
  logic [i_width-1:0] load_data;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/pat_run_ctrl.sv
// Run/load sequencer for the pat core: loads instruction memory, then runs, halts,
// single-steps and resumes the core, reporting halt cause and executed-cycle count.
module pat_run_ctrl #(
  parameter int i_adr_width     = 10,
  parameter int i_width         = 15,
  parameter int cycle_cnt_width = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       abort,
  pat_run_ctrl_if.slave              load,
  input  logic                       start,
  input  logic                       step,
  input  logic                       halt_req,
  input  logic                       bkpt_en,
  input  logic [i_adr_width-1:0]     bkpt_adr,
  input  logic [cycle_cnt_width-1:0] cycle_limit,
  input  logic [i_adr_width-1:0]     core_pc,
  output logic                       imem_we,
  output logic [i_adr_width-1:0]     imem_wadr,
  output logic [i_width-1:0]         imem_wdata,
  output logic [i_adr_width:0]       load_count,
  output logic                       core_reset,
  output logic                       core_clk_en,
  output logic                       running,
  output logic                       halted,
  output logic [1:0]                 halt_cause,
  output logic [cycle_cnt_width-1:0] cycle_count,
  output logic [1:0]                 dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_STEP = 2'd2, S_HALTED = 2'd3} state_t;

  localparam logic [i_adr_width:0]       load_one  = 1;
  localparam logic [cycle_cnt_width-1:0] cycle_one = 1;

  state_t state, state_n;
  logic   first_resume;
  logic   bkpt_hit, limit_hit, hit;

  // first_resume masks the breakpoint so a resume can step off the address it halted on.
  assign bkpt_hit  = bkpt_en && (core_pc == bkpt_adr) && !first_resume;
  assign limit_hit = (cycle_limit != '0) && (cycle_count == cycle_limit);
  assign hit       = halt_req || bkpt_hit || limit_hit;

  assign imem_we    = load.load_valid && load.load_ready;
  assign imem_wadr  = load_count[i_adr_width-1:0];
  assign imem_wdata = load.load_data;
  assign running    = (state == S_RUN) || (state == S_STEP);
  assign halted     = (state == S_HALTED);
  assign dbg_state  = state;

  always_comb begin
    state_n         = state;
    core_reset      = 1'b0;
    core_clk_en     = 1'b0;
    load.load_ready = 1'b0;
    case (state)
      S_IDLE: begin
        core_reset      = 1'b1;
        load.load_ready = !load_count[i_adr_width];
        if (start) state_n = S_RUN;
      end
      S_RUN: begin
        core_clk_en = !hit;
        if (hit) state_n = S_HALTED;
      end
      S_STEP: begin
        core_clk_en = 1'b1;
        state_n     = S_HALTED;
      end
      S_HALTED: begin
        if (start)     state_n = S_RUN;
        else if (step) state_n = S_STEP;
      end
      default: state_n = S_IDLE;
    endcase
    if (abort) state_n = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      first_resume <= 1'b0;
      load_count   <= '0;
      cycle_count  <= '0;
      halt_cause   <= 2'b00;
    end else begin
      state        <= state_n;
      first_resume <= (state == S_HALTED) && (state_n == S_RUN);

      if (abort)        load_count <= '0;
      else if (imem_we) load_count <= load_count + load_one;

      if (state == S_IDLE && start && !abort)
        cycle_count <= '0;
      else if (core_clk_en && cycle_count != '1)
        cycle_count <= cycle_count + cycle_one;

      // Cause priority when several hits coincide: host request, then breakpoint, then limit.
      if (!abort) begin
        if (state == S_RUN && hit)
          halt_cause <= halt_req ? 2'b01 : (bkpt_hit ? 2'b10 : 2'b11);
        else if (state == S_STEP)
          halt_cause <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_pat_run_ctrl.sv
// Directed bench for pat_run_ctrl: load, breakpoint, resume, cycle limit, step,
// memory-full and asynchronous reset scenarios with hand-computed expectations.
module tb_pat_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        abort, start, step, halt_req, bkpt_en;
  logic [9:0]  bkpt_adr;
  logic [15:0] cycle_limit;
  logic [9:0]  core_pc;
  logic        imem_we;
  logic [9:0]  imem_wadr;
  logic [14:0] imem_wdata;
  logic [10:0] load_count;
  logic        core_reset, core_clk_en, running, halted;
  logic [1:0]  halt_cause, dbg_state;
  logic [15:0] cycle_count;

  int total = 0;
  int bad   = 0;
  int wcount;

  pat_run_ctrl_if #(.i_width(15)) lif ();

  pat_run_ctrl dut (
    .clk(clk), .reset(reset), .abort(abort), .load(lif), .start(start), .step(step),
    .halt_req(halt_req), .bkpt_en(bkpt_en), .bkpt_adr(bkpt_adr), .cycle_limit(cycle_limit),
    .core_pc(core_pc), .imem_we(imem_we), .imem_wadr(imem_wadr), .imem_wdata(imem_wdata),
    .load_count(load_count), .core_reset(core_reset), .core_clk_en(core_clk_en),
    .running(running), .halted(halted), .halt_cause(halt_cause), .cycle_count(cycle_count),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Minimal core model: pc advances only on enabled cycles, cleared while held in reset.
  always @(posedge clk or posedge reset) begin
    if (reset)            core_pc <= '0;
    else if (core_reset)  core_pc <= '0;
    else if (core_clk_en) core_pc <= core_pc + 10'd1;
  end

  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; abort = 1'b0; start = 1'b0; step = 1'b0; halt_req = 1'b0;
    bkpt_en = 1'b1; bkpt_adr = 10'd7; cycle_limit = 16'd0;
    lif.load_valid = 1'b0; lif.load_data = '0;
    #2;
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_clk_en", 32'(core_clk_en), 32'd0);
    chk("rst_load_count", 32'(load_count), 32'd0);
    chk("rst_cycle_count", 32'(cycle_count), 32'd0);
    chk("rst_cause", 32'(halt_cause), 32'd0);
    chk("rst_run_halt", 32'({running, halted, imem_we}), 32'd0);
    tick(); tick();
    reset = 1'b0;

    // Load words 1..4, then word 5 together with start
    for (int i = 0; i < 4; i++) begin
      lif.load_valid = 1'b1; lif.load_data = 15'(i + 1);
      #2;
      chk("load_we", 32'(imem_we), 32'd1);
      chk("load_wadr", 32'(imem_wadr), 32'(i));
      chk("load_wdata", 32'(imem_wdata), 32'(i + 1));
      tick();
    end
    lif.load_data = 15'd5; start = 1'b1;
    #2;
    chk("load_start_we", 32'(imem_we), 32'd1);
    chk("load_start_wadr", 32'(imem_wadr), 32'd4);
    chk("load_start_wdata", 32'(imem_wdata), 32'd5);
    chk("start_core_reset_hi", 32'(core_reset), 32'd1);
    tick();
    lif.load_valid = 1'b0; start = 1'b0;
    chk("run_core_reset_lo", 32'(core_reset), 32'd0);
    chk("run_running", 32'(running), 32'd1);
    chk("run_load_count", 32'(load_count), 32'd5);
    chk("run_cycle_count0", 32'(cycle_count), 32'd0);
    chk("run_no_we", 32'(imem_we), 32'd0);

    // Breakpoint at pc 7: pcs 0..6 execute, pc 7 does not
    for (int k = 0; k < 7; k++) begin
      #2;
      chk("bkpt_run_en", 32'(core_clk_en), 32'd1);
      tick();
    end
    #2;
    chk("bkpt_stall_en", 32'(core_clk_en), 32'd0);
    tick();
    chk("bkpt_halted", 32'(halted), 32'd1);
    chk("bkpt_cause", 32'(halt_cause), 32'd2);
    chk("bkpt_count", 32'(cycle_count), 32'd7);
    chk("bkpt_held_en", 32'(core_clk_en), 32'd0);

    // Resume: pc 7 executes without re-halting, then a host halt
    start = 1'b1;
    tick();
    start = 1'b0;
    #2;
    chk("resume_pc7_en", 32'(core_clk_en), 32'd1);
    tick(); tick(); tick();
    chk("resume_still_run", 32'(running), 32'd1);
    halt_req = 1'b1;
    #2;
    chk("hreq_en_lo", 32'(core_clk_en), 32'd0);
    tick();
    halt_req = 1'b0;
    chk("hreq_halted", 32'(halted), 32'd1);
    chk("hreq_cause", 32'(halt_cause), 32'd1);
    chk("hreq_count", 32'(cycle_count), 32'd10);

    // Abort, then run against a cycle limit of 3
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", 32'(dbg_state), 32'd0);
    chk("abort_load_count", 32'(load_count), 32'd0);
    chk("abort_core_reset", 32'(core_reset), 32'd1);
    bkpt_en = 1'b0; cycle_limit = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < 4; j++) begin
      #2;
      chk("limit_en", 32'(core_clk_en), (j < 3) ? 32'd1 : 32'd0);
      tick();
    end
    chk("limit_halted", 32'(halted), 32'd1);
    chk("limit_cause", 32'(halt_cause), 32'd3);
    chk("limit_count", 32'(cycle_count), 32'd3);

    // Two single steps
    for (int s = 0; s < 2; s++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      #2;
      chk("step_en", 32'(core_clk_en), 32'd1);
      chk("step_state", 32'(dbg_state), 32'd2);
      tick();
      chk("step_halted", 32'(halted), 32'd1);
      chk("step_en_off", 32'(core_clk_en), 32'd0);
      chk("step_cause", 32'(halt_cause), 32'd0);
      chk("step_count", 32'(cycle_count), 32'(4 + s));
    end

    // step and start together: start wins
    step = 1'b1; start = 1'b1;
    tick();
    step = 1'b0; start = 1'b0;
    chk("both_state_run", 32'(dbg_state), 32'd1);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    chk("both_hreq_cause", 32'(halt_cause), 32'd1);

    // Fill all 1024 words; no write afterwards
    abort = 1'b1; cycle_limit = 16'd0;
    tick();
    abort = 1'b0;
    wcount = 0;
    lif.load_valid = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      lif.load_data = 15'(i + 100);
      #2;
      if (imem_we && imem_wadr == 10'(i) && imem_wdata == 15'(i + 100)) wcount++;
      tick();
    end
    chk("fill_writes", 32'(wcount), 32'd1024);
    #2;
    chk("fill_ready_lo", 32'(lif.load_ready), 32'd0);
    chk("fill_no_we", 32'(imem_we), 32'd0);
    chk("fill_count", 32'(load_count), 32'd1024);
    tick();
    chk("fill_no_we2", 32'(imem_we), 32'd0);
    lif.load_valid = 1'b0;

    // Asynchronous reset in the middle of a run
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_count", 32'(cycle_count), 32'd3);
    chk("pre_rst_running", 32'(running), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_core_reset", 32'(core_reset), 32'd1);
    chk("arst_cycle_count", 32'(cycle_count), 32'd0);
    chk("arst_load_count", 32'(load_count), 32'd0);
    chk("arst_running", 32'(running), 32'd0);
    chk("arst_clk_en", 32'(core_clk_en), 32'd0);
    tick();
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
